lib_voq_tx: RTL and testbench

Upstream-end transmitter for a virtual-output-queued router input.
- Buffers packets from the local switch output, each tagged with a destination index.
- Presents the head packet with a one-hot valid that selects the downstream VOQ virtual channel.
- Advances on the downstream per-VC enable.
- Flags head-of-line stalls.

---
 rtl/lib_voq_tx_pkg.sv | 29 ++
 rtl/lib_voq_tx_buf.sv | 68 ++++++
 rtl/lib_voq_tx.sv | 104 ++++++++++
 tb/tb_lib_voq_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lib_voq_tx_pkg.sv
// Shared types and helpers for the VOQ transmitter (lib_voq_tx).
// The packet format, one-hot VC decode and buffer width helpers live here.
package lib_voq_tx_pkg;

    typedef struct packed {
        logic [3:0]  tag;
        logic [11:0] payload;
    } packet_t;

    // Widest VC fan-out the one-hot helper can produce.
    localparam int MAX_VC = 32;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // VC idx maps to bit idx counting from the left (bit 0 = VC 0).
    function automatic logic [0:MAX_VC-1] onehot_msb(input int unsigned idx, input int unsigned m);
        logic [0:MAX_VC-1] v;
        v = '0;
        if (idx < m && idx < MAX_VC) v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/lib_voq_tx_buf.sv
// Circular packet buffer with registered first-word-fall-through head.
// The head registers hold their last value when the buffer drains.
module lib_voq_tx_buf
    import lib_voq_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW = 2,
    localparam int PW = ptr_w(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  packet_t       wr_data,
    input  logic [DW-1:0] wr_dest,
    output packet_t       head_data,
    output logic [DW-1:0] head_dest,
    output logic          head_val,
    output logic [CW-1:0] count_next
);

    packet_t       mem_data [DEPTH];
    logic [DW-1:0] mem_dest [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] remain;

    always_comb begin
        rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
        remain      = pop ? count - 1'b1 : count;
        count_next  = push ? remain + 1'b1 : remain;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= wr_data;
            mem_dest[wr_ptr] <= wr_dest;
        end
    end

    // The next head is an older entry if any survive the pop, else the word being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_val  <= 1'b0;
            head_data <= '0;
            head_dest <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            head_val <= (count_next != '0);
            if (remain != '0) begin
                head_data <= mem_data[rd_ptr_next];
                head_dest <= mem_dest[rd_ptr_next];
            end else if (push) begin
                head_data <= wr_data;
                head_dest <= wr_dest;
            end
        end
    end

endmodule

// File: rtl/lib_voq_tx.sv
// VOQ transmitter: buffers tagged packets, presents a one-hot VC valid, flags HOL stalls.
// Define LIB_VOQ_TX_STATS_EN to add per-VC transmit and drop counters.
module lib_voq_tx
    import lib_voq_tx_pkg::*;
#(
    parameter int M = 4,
    parameter int DEPTH = 4,
    parameter int STALL_LIMIT = 16,
    localparam int DW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  packet_t       i_data,
    input  logic          i_data_val,
    input  logic [DW-1:0] i_dest,
    output logic          o_en,
    output packet_t       o_data,
    output logic [0:M-1]  o_data_val,
    input  logic          i_en,
    output logic          o_stall
`ifdef LIB_VOQ_TX_STATS_EN
    ,
    output logic [0:M-1][15:0] o_tx_count,
    output logic [15:0]        o_drop_count
`endif
);

    localparam int CW = cnt_w(DEPTH);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    // Handshake: a word moves on a ce edge only when its valid and the matching enable are both high.
    logic              dest_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic              head_val;
    logic [DW-1:0]     head_dest;
    logic [CW-1:0]     count_next;
    logic [SW-1:0]     stall_cnt;
    logic [SW-1:0]     stall_next;
    logic [0:MAX_VC-1] head_oh;
    logic              oh_unused;

    assign dest_ok = int'(i_dest) < M;
    assign accept  = ce & i_data_val & o_en;
    assign push    = accept & dest_ok;
    assign pop     = ce & head_val & i_en;

    lib_voq_tx_buf #(.DEPTH(DEPTH), .DW(DW)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .wr_data    (i_data),
        .wr_dest    (i_dest),
        .head_data  (o_data),
        .head_dest  (head_dest),
        .head_val   (head_val),
        .count_next (count_next)
    );

    // Valid is decoded purely from registered head state; downstream ready depends on it.
    always_comb begin
        head_oh    = onehot_msb(32'(head_dest), M);
        o_data_val = head_val ? head_oh[0:M-1] : '0;
    end
    assign oh_unused = ^head_oh;

    always_comb begin
        stall_next = stall_cnt;
        if (!head_val || pop) stall_next = '0;
        else if (int'(stall_cnt) < STALL_LIMIT) stall_next = stall_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_en      <= 1'b0;
            stall_cnt <= '0;
            o_stall   <= 1'b0;
        end else if (ce) begin
            o_en      <= int'(count_next) < DEPTH;
            stall_cnt <= stall_next;
            o_stall   <= int'(stall_next) == STALL_LIMIT;
        end
    end

`ifdef LIB_VOQ_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_tx_count   <= '0;
            o_drop_count <= '0;
        end else begin
            for (int k = 0; k < M; k++) begin
                if (pop && int'(head_dest) == k && o_tx_count[k] != 16'hFFFF)
                    o_tx_count[k] <= o_tx_count[k] + 16'd1;
            end
            if (accept && !dest_ok && o_drop_count != 16'hFFFF)
                o_drop_count <= o_drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lib_voq_tx.sv
// Randomised scoreboard bench for lib_voq_tx (M=4, DEPTH=4, STALL_LIMIT=16).
// The reference model is a packet queue plus a blocked-cycle run length.
module tb_lib_voq_tx;
    import lib_voq_tx_pkg::*;

    localparam int M = 4;
    localparam int DEPTH = 4;
    localparam int STALL_LIMIT = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce;
    packet_t      i_data;
    logic         i_data_val;
    logic [1:0]   i_dest;
    logic         o_en;
    packet_t      o_data;
    logic [0:M-1] o_data_val;
    logic         i_en;
    logic         o_stall;
`ifdef LIB_VOQ_TX_STATS_EN
    logic [0:M-1][15:0] o_tx_count;
    logic [15:0]        o_drop_count;
    int                 m_tx [M];
`endif

    lib_voq_tx #(.M(M), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .i_data     (i_data),
        .i_data_val (i_data_val),
        .i_dest     (i_dest),
        .o_en       (o_en),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .i_en       (i_en),
        .o_stall    (o_stall)
`ifdef LIB_VOQ_TX_STATS_EN
        ,
        .o_tx_count   (o_tx_count),
        .o_drop_count (o_drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard state: queued packets as {data, dest}.
    logic [17:0]  exp_q [$];
    logic         m_en = 1'b0;
    int           run = 0;
    packet_t      last_data = '0;
    int           checks = 0;
    int           errors = 0;
    logic [0:M-1] ev;
    packet_t      ed;
    logic [1:0]   pd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor compares registered outputs, then the model absorbs the inputs for the next edge.
    always @(negedge clk) begin
        ev = '0;
        ed = last_data;
        if (exp_q.size() > 0) begin
            pd = exp_q[0][1:0];
            ev[pd] = 1'b1;
            ed = packet_t'(exp_q[0][17:2]);
        end
        check("o_en", 32'(o_en), 32'(m_en));
        check("o_data_val", 32'(o_data_val), 32'(ev));
        check("o_data", 32'(o_data), 32'(ed));
        check("o_stall", 32'(o_stall), 32'(run >= STALL_LIMIT));
`ifdef LIB_VOQ_TX_STATS_EN
        for (int k = 0; k < M; k++) check("o_tx_count", 32'(o_tx_count[k]), 32'(m_tx[k]));
        check("o_drop_count", 32'(o_drop_count), 32'd0);
`endif
        if (reset) begin
            exp_q.delete();
            m_en = 1'b0;
            run = 0;
            last_data = '0;
`ifdef LIB_VOQ_TX_STATS_EN
            for (int k = 0; k < M; k++) m_tx[k] = 0;
`endif
        end else if (ce) begin
            if (exp_q.size() > 0 && !i_en) run++;
            else run = 0;
            if (exp_q.size() > 0 && i_en) begin
`ifdef LIB_VOQ_TX_STATS_EN
                m_tx[exp_q[0][1:0]]++;
`endif
                void'(exp_q.pop_front());
            end
            if (i_data_val && m_en) exp_q.push_back({i_data, i_dest});
            if (exp_q.size() > 0) last_data = packet_t'(exp_q[0][17:2]);
            m_en = exp_q.size() < DEPTH;
        end
    end

    task automatic step(input logic c, input logic dv, input logic [1:0] dst, input logic en);
        ce = c;
        i_data_val = dv;
        i_dest = dst;
        i_data = packet_t'(16'($urandom));
        i_en = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en_pct;
        reset = 1'b1;
        ce = 1'b1;
        i_data = '0;
        i_data_val = 1'b0;
        i_dest = '0;
        i_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 0, 0, 0);
        // Single packet to VC 2 with downstream always ready.
        step(1, 1, 2, 1);
        repeat (2) step(1, 0, 0, 1);
        // Fill with dests 0..3 while blocked, try a fifth push, then drain.
        for (int d = 0; d < 4; d++) step(1, 1, 2'(d), 0);
        step(1, 1, 1, 0);
        repeat (6) step(1, 0, 0, 1);
        // Full buffer: push attempt coincides with a pop.
        for (int d = 0; d < 4; d++) step(1, 1, 2'(3 - d), 0);
        step(1, 1, 0, 1);
        step(1, 1, 1, 0);
        repeat (5) step(1, 0, 0, 1);
        // Head-of-line stall on VC 1.
        step(1, 1, 1, 0);
        repeat (20) step(1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 1);
        // Clock enable low freezes everything despite active inputs.
        step(1, 1, 0, 0);
        step(1, 1, 3, 0);
        repeat (5) step(0, 1, 2, 1);
        repeat (4) step(1, 0, 0, 1);
        // Reset while packets are in flight.
        for (int d = 0; d < 3; d++) step(1, 1, 2'(d), 0);
        reset = 1'b1;
        step(1, 1, 1, 1);
        reset = 1'b0;
        repeat (2) step(1, 0, 0, 1);
        // Random traffic with alternating downstream pressure.
        for (int i = 0; i < 3000; i++) begin
            en_pct = ((i / 300) % 2 == 1) ? 90 : 10;
            reset = ($urandom_range(0, 499) == 0);
            step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 99) < en_pct);
        end
        reset = 1'b0;
        repeat (8) step(1, 0, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
